// File: rtl/wb_patch_fetch_if.sv
// wb_patch_fetch_if: classic Wishbone read bus between the patch fetcher and the SDRAM slave
interface wb_patch_fetch_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        sdram_ack;
  modport master (
    output cyc_i, stb_i, we_i, sel_i, addr_i, data_i,
    input  data_o, stall_o, sdram_ack
  );
  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, addr_i, data_i,
    output data_o, stall_o, sdram_ack
  );
endinterface

// File: rtl/wb_patch_fetch.sv
// wb_patch_fetch: reads a 3x3 patch of 16-bit elements over Wishbone and presents it as one packed vector
module wb_patch_fetch #(
  parameter int N_ELEM  = 9,
  parameter int ELEM_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              base_addr,
  output logic [N_ELEM*ELEM_W-1:0] patch,
  output logic                     patch_valid,
  input  logic                     patch_ready,
  output logic                     busy,
  output logic                     err,
  wb_patch_fetch_if.master         wb
);
  localparam int IW = $clog2(N_ELEM);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, GAP, DONE, ERR} state_t;
  state_t                   r_state, w_next;
  logic [31:0]              r_base;
  logic [IW-1:0]            r_idx;
  logic [7:0]               r_cnt;
  logic [N_ELEM*ELEM_W-1:0] r_patch;
  logic                     r_valid;
  logic                     w_cap;
  logic                     w_last;
  logic                     w_to;
  assign w_last = r_idx == IW'(N_ELEM - 1);
  assign w_to   = r_cnt == 8'(TIMEOUT);
  // state register
  always_ff @(posedge CLK) r_state <= rst ? IDLE : w_next;
  // next state and element capture strobe; an unstalled REQ may take its ack immediately
  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    case (r_state)
      IDLE: w_next = start && !r_valid ? REQ : IDLE;
      REQ: begin
        w_cap  = !wb.stall_o && wb.sdram_ack;
        w_next = !wb.stall_o ? (wb.sdram_ack ? (w_last ? DONE : GAP) : WAIT) : (w_to ? ERR : REQ);
      end
      WAIT: begin
        w_cap  = wb.sdram_ack;
        w_next = wb.sdram_ack ? (w_last ? DONE : GAP) : (w_to ? ERR : WAIT);
      end
      GAP: w_next = REQ;
      default: w_next = IDLE;
    endcase
  end
  // base/index, saturating timeout, patch slots and result handshake
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_base  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_patch <= '0;
      r_valid <= 1'b0;
    end else begin
      if (r_state == IDLE && w_next == REQ) begin
        r_base <= base_addr;
        r_idx  <= '0;
      end else if (w_cap && !w_last) r_idx <= r_idx + 1'b1;
      r_cnt <= (r_state == REQ || r_state == WAIT) ? r_cnt + {7'd0, r_cnt != 8'hFF} : 8'd0;
      for (int k = 0; k < N_ELEM; k++)
        if (w_cap && r_idx == IW'(k)) r_patch[k*ELEM_W +: ELEM_W] <= wb.data_o[ELEM_W-1:0];
      r_valid <= r_state == DONE || (r_valid && !patch_ready);
    end
  end
  assign wb.cyc_i    = r_state == REQ || r_state == WAIT;
  assign wb.stb_i    = r_state == REQ || r_state == WAIT;
  assign wb.we_i     = 1'b0;
  assign wb.sel_i    = 4'b1111;
  assign wb.data_i   = '0;
  assign wb.addr_i   = r_base + 32'(r_idx);
  assign patch       = r_patch;
  assign patch_valid = r_valid;
  assign busy        = r_state != IDLE;
  assign err         = r_state == ERR;
endmodule

// File: tb/tb_wb_patch_fetch.sv
// tb_wb_patch_fetch: directed checks of wb_patch_fetch against a behavioural SDRAM slave
module tb_wb_patch_fetch;
  logic         CLK = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         patch_ready = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [143:0] patch;
  logic         patch_valid;
  logic         busy;
  logic         err;
  int errors = 0;
  int checks = 0;

  wb_patch_fetch_if wb ();

  wb_patch_fetch dut (
    .CLK(CLK), .rst(rst), .start(start), .base_addr(base_addr),
    .patch(patch), .patch_valid(patch_valid), .patch_ready(patch_ready),
    .busy(busy), .err(err), .wb(wb)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:63];
  int          lat = 3;
  logic        noack_en = 1'b0;
  logic [31:0] noack_addr = '0;
  logic        sack = 1'b0;
  int          scnt = 0;

  assign wb.data_o    = mem[wb.addr_i[5:0]];
  assign wb.stall_o   = 1'b0;
  assign wb.sdram_ack = sack;

  // slave: ack after lat cycles of cyc, ack persists while cyc stays high
  always @(posedge CLK) begin
    if (!wb.cyc_i) begin
      scnt <= 0;
      sack <= 1'b0;
    end else if (!sack && !(noack_en && wb.addr_i == noack_addr)) begin
      if (scnt == lat - 1) sack <= 1'b1;
      else scnt <= scnt + 1;
    end
  end

  int          cyc_hi = 0;
  int          gaps = 0;
  int          gap_bad = 0;
  int          low_run = 0;
  int          to_cyc = 0;
  int          acnt = 0;
  logic        prev_cyc = 1'b0;
  logic [31:0] alog [0:127];

  // bus monitor: cyc activity, acked addresses, one-cycle gaps, cycles spent on the unacked address
  always @(posedge CLK) begin
    if (wb.cyc_i) cyc_hi <= cyc_hi + 1;
    if (wb.cyc_i && sack) begin
      if (acnt < 128) alog[acnt] <= wb.addr_i;
      acnt <= acnt + 1;
    end
    if (noack_en && wb.cyc_i && wb.addr_i == noack_addr) to_cyc <= to_cyc + 1;
    low_run <= (!busy || wb.cyc_i) ? 0 : low_run + 1;
    if (busy && wb.cyc_i && !prev_cyc && low_run == 1) gaps <= gaps + 1;
    if (busy && wb.cyc_i && !prev_cyc && low_run > 1) gap_bad <= gap_bad + 1;
    prev_cyc <= wb.cyc_i;
  end

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic fetch(input logic [31:0] b);
    base_addr = b;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!patch_valid && n < 300) begin
      tick(1);
      n++;
    end
    chk(tag, 144'(patch_valid), 144'(1));
  endtask

  localparam logic [143:0] P_NOM = 144'h0018_0017_0016_0015_1234_0013_0012_0011_0010;
  localparam logic [143:0] P_SEC = 144'h0118_0115_0112_010F_010C_0109_0106_0103_0100;
  localparam logic [143:0] P_TO  = 144'h0118_0115_0112_010F_010C_0109_0106_0011_0010;

  initial begin
    int a0, g0, c0, t0, n;
    for (int k = 0; k < 64; k++) mem[k] = 32'hDEAD_0000 | 32'(k);
    for (int k = 0; k < 9; k++) mem[32+k] = 32'h10 + 32'(k);
    mem[36] = 32'hABCD_1234;
    for (int k = 0; k < 9; k++) mem[48+k] = 32'hFFFF_0100 + 32'(3 * k);

    tick(3);
    chk("rst_cyc", 144'(wb.cyc_i), 144'(0));
    chk("rst_stb", 144'(wb.stb_i), 144'(0));
    chk("rst_addr", 144'(wb.addr_i), 144'(0));
    chk("rst_patch", patch, 144'(0));
    chk("rst_valid", 144'(patch_valid), 144'(0));
    chk("rst_busy", 144'(busy), 144'(0));
    chk("rst_err", 144'(err), 144'(0));
    chk("const_we", 144'(wb.we_i), 144'(0));
    chk("const_sel", 144'(wb.sel_i), 144'(4'hF));
    chk("const_data", 144'(wb.data_i), 144'(0));
    rst = 1'b0;
    tick(5);
    chk("idle_no_cyc", 144'(cyc_hi), 144'(0));
    chk("idle_busy", 144'(busy), 144'(0));

    a0 = acnt;
    g0 = gaps;
    fetch(32'h20);
    chk("nom_busy", 144'(busy), 144'(1));
    wait_valid("nom_valid");
    chk("nom_nacc", 144'(acnt - a0), 144'(9));
    for (int k = 0; k < 9; k++) chk($sformatf("nom_addr%0d", k), 144'(alog[a0+k]), 144'(32'h20 + 32'(k)));
    chk("nom_gaps", 144'(gaps - g0), 144'(8));
    chk("nom_gap_bad", 144'(gap_bad), 144'(0));
    chk("nom_slot0", 144'(patch[15:0]), 144'(16'h0010));
    chk("nom_slot8", 144'(patch[143:128]), 144'(16'h0018));
    chk("nom_slot4_low", 144'(patch[79:64]), 144'(16'h1234));
    chk("nom_patch", patch, P_NOM);
    chk("nom_idle", 144'(busy), 144'(0));

    c0 = cyc_hi;
    tick(10);
    fetch(32'h30);
    tick(20);
    fetch(32'h30);
    tick(18);
    chk("bp_no_cyc", 144'(cyc_hi - c0), 144'(0));
    chk("bp_valid", 144'(patch_valid), 144'(1));
    chk("bp_patch", patch, P_NOM);
    chk("bp_busy", 144'(busy), 144'(0));
    patch_ready = 1'b1;
    tick(1);
    patch_ready = 1'b0;
    chk("bp_consumed", 144'(patch_valid), 144'(0));
    chk("bp_patch_kept", patch, P_NOM);

    fetch(32'h30);
    wait_valid("sec_valid");
    chk("sec_patch", patch, P_SEC);
    chk("sec_gap_bad", 144'(gap_bad), 144'(0));

    c0 = cyc_hi;
    base_addr = 32'h20;
    start = 1'b1;
    patch_ready = 1'b1;
    tick(1);
    start = 1'b0;
    patch_ready = 1'b0;
    chk("both_valid", 144'(patch_valid), 144'(0));
    chk("both_busy", 144'(busy), 144'(0));
    tick(3);
    chk("both_no_cyc", 144'(cyc_hi - c0), 144'(0));

    noack_en = 1'b1;
    noack_addr = 32'h22;
    t0 = to_cyc;
    fetch(32'h20);
    n = 0;
    while (!err && n < 400) begin
      tick(1);
      n++;
    end
    chk("to_err", 144'(err), 144'(1));
    chk("to_cyc_low", 144'(wb.cyc_i), 144'(0));
    chk("to_valid", 144'(patch_valid), 144'(0));
    chk("to_wait_cycles", 144'(to_cyc - t0), 144'(256));
    chk("to_patch", patch, P_TO);
    tick(1);
    chk("to_err_pulse", 144'(err), 144'(0));
    chk("to_busy", 144'(busy), 144'(0));
    chk("to_valid_after", 144'(patch_valid), 144'(0));
    noack_en = 1'b0;

    fetch(32'h20);
    n = 0;
    while (!(wb.cyc_i && wb.addr_i == 32'h25) && n < 200) begin
      tick(1);
      n++;
    end
    chk("mr_reach_e5", 144'(wb.cyc_i && wb.addr_i == 32'h25), 144'(1));
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("mr_cyc", 144'(wb.cyc_i), 144'(0));
    chk("mr_stb", 144'(wb.stb_i), 144'(0));
    chk("mr_patch", patch, 144'(0));
    chk("mr_valid", 144'(patch_valid), 144'(0));
    chk("mr_busy", 144'(busy), 144'(0));
    rst = 1'b0;
    tick(2);
    a0 = acnt;
    fetch(32'h20);
    wait_valid("mr_refetch_valid");
    chk("mr_refetch_patch", patch, P_NOM);
    chk("mr_refetch_nacc", 144'(acnt - a0), 144'(9));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
